// File: rtl/riscv_dmem_resp.sv
// Data-memory responder: valid/ready request and response channels around a word RAM with WAIT_CYCLES wait states.
// Optional `DMEM_RESP_ERR_CHECK_EN rejects misaligned or out-of-range addresses with o_rsp_err.
module riscv_dmem_resp #(
  parameter int XLEN          = 32,
  parameter int DMEM_ADDR_BIT = 12,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_wr_en,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [3:0]      i_req_strb,
  input  logic [XLEN-1:0] i_req_wr_data,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_data,
  output logic            o_rsp_err
);

  localparam int IDX_W = DMEM_ADDR_BIT - 2;
  localparam int WORDS = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        strb_q, strb_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              bad_q, bad_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic [XLEN-1:0]   ram [WORDS];
  logic [XLEN-1:0]   cur_word;
  logic [XLEN-1:0]   merged_word;
  logic              do_write;

`ifdef DMEM_RESP_ERR_CHECK_EN
  logic req_bad;
  assign req_bad = (i_req_addr[1:0] != 2'b00) || ((i_req_addr >> DMEM_ADDR_BIT) != '0);
`else
  // Without error checking the low and high address bits are don't-cares, so the RAM aliases.
  logic req_bad;
  logic unused_addr_bits;
  assign req_bad          = 1'b0;
  assign unused_addr_bits = ^{i_req_addr[1:0], i_req_addr[XLEN-1:DMEM_ADDR_BIT]};
`endif

  assign cur_word = ram[idx_q];

  always_comb begin
    merged_word = cur_word;
    for (int k = 0; k < 4; k++) begin
      if (strb_q[k]) merged_word[8*k +: 8] = wdata_q[8*k +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_en_d    = wr_en_q;
    idx_d      = idx_q;
    strb_d     = strb_q;
    wdata_d    = wdata_q;
    bad_d      = bad_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    do_write   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          wr_en_d = i_req_wr_en;
          idx_d   = i_req_addr[DMEM_ADDR_BIT-1:2];
          strb_d  = i_req_strb;
          wdata_d = i_req_wr_data;
          bad_d   = req_bad;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (bad_q) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end else begin
            rsp_data_d = wr_en_q ? merged_word : cur_word;
            rsp_err_d  = 1'b0;
            do_write   = wr_en_q && (strb_q != 4'b0000);
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    wr_en_q <= wr_en_d;
    idx_q   <= idx_d;
    strb_q  <= strb_d;
    wdata_q <= wdata_d;
    bad_q   <= bad_d;
  end

  // A reset in the access cycle cancels the write along with the transaction.
  always_ff @(posedge i_clk) begin
    if (do_write && !i_rst) ram[idx_q] <= merged_word;
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;

endmodule
